pipe_stage_skid: RTL

- Parametrised pipeline stage register, successor to the fixed IF/ID latch.
- Generic payload width; valid/ready handshake instead of a bare write-enable; 2-entry skid buffer so in_ready is a pure flop output; synchronous flush for branch/exception squash.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...), one instance per boundary.

---
 rtl/pipe_stage_skid.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W     = 96,
    parameter logic [DATA_W-1:0] FLUSH_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
`endif
    output logic [DATA_W-1:0] out_data
);

    // Bit 0 = out_valid, bit 1 = skid occupied (in_ready low).
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] TWO   = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept;
    logic              pop;

    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = FLUSH_DATA;
            skid_d  = FLUSH_DATA;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_DATA;
            skid_q  <= FLUSH_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
